ysyx_25030077_imm_pipe: RTL and testbench

Parametrised, pipelined immediate-generation stage for the NPC decode path, placed between the instruction decoder and the execute stage. It covers every RV32/RV64 immediate format, including the B and J formats, and supports XLEN of 32 or 64. It also pre-computes the branch/jump target (pc + imm). Input and output use valid/ready handshakes, and a 2-entry skid buffer keeps full throughput under back-pressure. A synchronous flush discards in-flight entries on redirect.

---
 rtl/ysyx_25030077_imm_pkg.sv | 36 +++
 rtl/ysyx_25030077_imm_pipe_if.sv | 40 ++++
 rtl/ysyx_25030077_imm_pipe_dec.sv | 48 ++++
 rtl/ysyx_25030077_imm_pipe.sv | 98 +++++++++
 tb/tb_ysyx_25030077_imm_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25030077_imm_pkg.sv
// Shared types and constants for the NPC immediate-generation pipe.
// Optional feature macro used by this slice: YSYX_25030077_IMM_ALIGN_CHECK_EN.
package ysyx_25030077_imm_pkg;

    localparam int IMM_TYPE_W = 4;
    localparam int INSN_W     = 32;
    localparam int MAX_XLEN   = 64;

    // Immediate format selector; encodings 10..15 behave as IMM_NONE.
    typedef enum logic [IMM_TYPE_W-1:0] {
        IMM_NONE    = 4'd0,
        IMM_I       = 4'd1,
        IMM_U       = 4'd2,
        IMM_PC4     = 4'd3,
        IMM_S       = 4'd4,
        IMM_SHAMT   = 4'd5,
        IMM_CSRADDR = 4'd6,
        IMM_B       = 4'd7,
        IMM_J       = 4'd8,
        IMM_ZIMM    = 4'd9
    } imm_type_e;

    // Widest view of one pipeline entry (XLEN=64 layout).
    typedef struct packed {
        logic [MAX_XLEN-1:0] imm;
        logic [MAX_XLEN-1:0] target;
        imm_type_e           imm_type;
        logic                misalign;
    } imm_entry_t;

    // Control-transfer formats whose target must be 4-byte aligned.
    function automatic logic is_branch_type(input logic [IMM_TYPE_W-1:0] t);
        return (t == IMM_B) || (t == IMM_J);
    endfunction

endpackage

// File: rtl/ysyx_25030077_imm_pipe_if.sv
// Handshake and data bundle between decoder, imm pipe and execute stage.
// With YSYX_25030077_IMM_ALIGN_CHECK_EN defined an extra misalign flag is carried.
interface ysyx_25030077_imm_pipe_if #(
    parameter int XLEN = 32
);
    import ysyx_25030077_imm_pkg::*;

    logic                  io_in_valid;
    logic                  io_in_ready;
    logic [INSN_W-1:0]     io_in_instruction;
    logic [IMM_TYPE_W-1:0] io_in_imm_type;
    logic [XLEN-1:0]       io_in_pc;
    logic                  io_out_valid;
    logic                  io_out_ready;
    logic [XLEN-1:0]       io_out_imm;
    logic [XLEN-1:0]       io_out_target;
    logic [IMM_TYPE_W-1:0] io_out_imm_type;
`ifdef YSYX_25030077_IMM_ALIGN_CHECK_EN
    logic                  io_out_misalign;
`endif

    // Pipe side: consumes the input entry, produces the output entry.
    modport slave (
        input  io_in_valid, io_in_instruction, io_in_imm_type, io_in_pc, io_out_ready,
`ifdef YSYX_25030077_IMM_ALIGN_CHECK_EN
        output io_out_misalign,
`endif
        output io_in_ready, io_out_valid, io_out_imm, io_out_target, io_out_imm_type
    );

    // Surrounding side: decoder drives inputs, execute stage drains outputs.
    modport master (
        output io_in_valid, io_in_instruction, io_in_imm_type, io_in_pc, io_out_ready,
`ifdef YSYX_25030077_IMM_ALIGN_CHECK_EN
        input  io_out_misalign,
`endif
        input  io_in_ready, io_out_valid, io_out_imm, io_out_target, io_out_imm_type
    );

endinterface

// File: rtl/ysyx_25030077_imm_pipe_dec.sv
// Combinational immediate decoder: raw instruction + format selector -> XLEN immediate.
// Not affected by YSYX_25030077_IMM_ALIGN_CHECK_EN.
module ysyx_25030077_imm_dec
    import ysyx_25030077_imm_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ILEN_BYTES = 4
) (
    input  logic [INSN_W-1:0]     insn,
    input  logic [IMM_TYPE_W-1:0] imm_type,
    output logic [XLEN-1:0]       imm
);

    // Sign-carrying 32-bit forms; widening them to XLEN sign-extends.
    logic signed [31:0] sx_i;
    logic signed [31:0] sx_u;
    logic signed [31:0] sx_s;
    logic signed [31:0] sx_b;
    logic signed [31:0] sx_j;
    logic               unused_opcode;

    assign sx_i = {{20{insn[31]}}, insn[31:20]};
    assign sx_u = {insn[31:12], 12'h000};
    assign sx_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign sx_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign sx_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

    // The opcode field never contributes to an immediate.
    assign unused_opcode = ^insn[6:0];

    // Select the immediate for the requested format; unknown selectors give zero.
    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:       imm = XLEN'(sx_i);
            IMM_U:       imm = XLEN'(sx_u);
            IMM_PC4:     imm = XLEN'(ILEN_BYTES);
            IMM_S:       imm = XLEN'(sx_s);
            IMM_SHAMT:   imm = (XLEN == 64) ? XLEN'(insn[25:20]) : XLEN'(insn[24:20]);
            IMM_CSRADDR: imm = XLEN'(insn[31:20]);
            IMM_B:       imm = XLEN'(sx_b);
            IMM_J:       imm = XLEN'(sx_j);
            IMM_ZIMM:    imm = XLEN'(insn[19:15]);
            default:     imm = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_25030077_imm_pipe.sv
// Pipelined immediate generation with pc+imm target and a 2-entry skid buffer.
// Define YSYX_25030077_IMM_ALIGN_CHECK_EN to add the registered io_out_misalign flag.
module ysyx_25030077_imm_pipe
    import ysyx_25030077_imm_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ILEN_BYTES = 4
) (
    input logic                     clock,
    input logic                     reset,
    input logic                     io_flush,
    ysyx_25030077_imm_pipe_if.slave io
);

    // One stored entry, sized to this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       target;
        logic [IMM_TYPE_W-1:0] imm_type;
`ifdef YSYX_25030077_IMM_ALIGN_CHECK_EN
        logic                  misalign;
`endif
    } stage_t;

    logic [XLEN-1:0] dec_imm;
    stage_t          new_entry;
    stage_t          m_entry;
    stage_t          k_entry;
    logic            m_valid;
    logic            k_valid;
    logic            in_accept;
    logic            out_fire;

    ysyx_25030077_imm_dec #(
        .XLEN       (XLEN),
        .ILEN_BYTES (ILEN_BYTES)
    ) u_dec (
        .insn     (io.io_in_instruction),
        .imm_type (io.io_in_imm_type),
        .imm      (dec_imm)
    );

    // Ready depends only on the skid register, so no path from io_out_ready.
    assign in_accept = io.io_in_valid && !k_valid;
    assign out_fire  = m_valid && io.io_out_ready;

    // Build the entry to capture: immediate, wrapping pc+imm, echoed type.
    always_comb begin
        new_entry          = '0;
        new_entry.imm      = dec_imm;
        new_entry.target   = io.io_in_pc + dec_imm;
        new_entry.imm_type = io.io_in_imm_type;
`ifdef YSYX_25030077_IMM_ALIGN_CHECK_EN
        new_entry.misalign = is_branch_type(io.io_in_imm_type) && new_entry.target[1];
`endif
    end

    // Main (M) and skid (K) registers: K always holds the younger entry, so
    // draining K into M on a fire keeps FIFO order; flush beats accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            k_valid <= 1'b0;
            m_entry <= '0;
            k_entry <= '0;
        end else if (io_flush) begin
            m_valid <= 1'b0;
            k_valid <= 1'b0;
        end else if (out_fire) begin
            if (k_valid) begin
                m_entry <= k_entry;
                k_valid <= 1'b0;
            end else if (in_accept) begin
                m_entry <= new_entry;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (m_valid) begin
            if (in_accept) begin
                k_entry <= new_entry;
                k_valid <= 1'b1;
            end
        end else if (in_accept) begin
            m_entry <= new_entry;
            m_valid <= 1'b1;
        end
    end

    assign io.io_in_ready     = !k_valid;
    assign io.io_out_valid    = m_valid;
    assign io.io_out_imm      = m_entry.imm;
    assign io.io_out_target   = m_entry.target;
    assign io.io_out_imm_type = m_entry.imm_type;
`ifdef YSYX_25030077_IMM_ALIGN_CHECK_EN
    assign io.io_out_misalign = m_entry.misalign;
`endif

endmodule

// File: tb/tb_ysyx_25030077_imm_pipe.sv
// Self-checking bench for ysyx_25030077_imm_pipe at XLEN=32 and XLEN=64.
// Honours YSYX_25030077_IMM_ALIGN_CHECK_EN when checking io_out_misalign.
module tb_ysyx_25030077_imm_pipe;

    logic clock;
    logic reset;
    logic io_flush;
    logic rdy_toggle;
    int   checks;
    int   failures;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [3:0]  typ;
        logic        mis;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    ysyx_25030077_imm_pipe_if #(.XLEN(32)) bus32 ();
    ysyx_25030077_imm_pipe_if #(.XLEN(64)) bus64 ();

    ysyx_25030077_imm_pipe #(.XLEN(32), .ILEN_BYTES(4)) dut32 (
        .clock    (clock),
        .reset    (reset),
        .io_flush (io_flush),
        .io       (bus32)
    );

    ysyx_25030077_imm_pipe #(.XLEN(64), .ILEN_BYTES(4)) dut64 (
        .clock    (clock),
        .reset    (reset),
        .io_flush (io_flush),
        .io       (bus64)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison: count it, report it if it differs.
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Sign-interpret the low 'bits' bits of raw.
    function automatic longint sx(input longint raw, input int bits);
        if (raw[bits-1]) return raw - (longint'(1) << bits);
        return raw;
    endfunction

    // Reference: immediate as an arithmetic value, then masked to XLEN.
    function automatic exp_t model(input logic [31:0] i, input logic [3:0] t,
                                   input logic [63:0] pc, input int xlen);
        exp_t        e;
        longint      v;
        logic [63:0] mask;
        case (t)
            4'd1: v = sx(longint'(i[31:20]), 12);
            4'd2: v = sx(longint'(i[31:12]), 20) * 4096;
            4'd3: v = 4;
            4'd4: v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
            4'd5: v = (xlen == 32) ? longint'(i[24:20]) : longint'(i[25:20]);
            4'd6: v = longint'(i[31:20]);
            4'd7: v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                         longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            4'd8: v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
                         longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
            4'd9: v = longint'(i[19:15]);
            default: v = 0;
        endcase
        mask  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        e.imm = 64'(v) & mask;
        e.tgt = (pc + e.imm) & mask;
        e.typ = t;
        e.mis = ((t == 4'd7) || (t == 4'd8)) && e.tgt[1];
        return e;
    endfunction

    // Scoreboard for the XLEN=32 instance, evaluated mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            q32.delete();
            chk("rst_valid32", 64'(bus32.io_out_valid), 64'd0);
            chk("rst_ready32", 64'(bus32.io_in_ready), 64'd1);
            chk("rst_imm32", 64'(bus32.io_out_imm), 64'd0);
            chk("rst_tgt32", 64'(bus32.io_out_target), 64'd0);
            chk("rst_type32", 64'(bus32.io_out_imm_type), 64'd0);
        end else begin
            chk("in_ready32", 64'(bus32.io_in_ready), 64'(q32.size() < 2));
            chk("out_valid32", 64'(bus32.io_out_valid), 64'(q32.size() > 0));
            if (bus32.io_out_valid && q32.size() > 0) begin
                chk("imm32", 64'(bus32.io_out_imm), q32[0].imm);
                chk("target32", 64'(bus32.io_out_target), q32[0].tgt);
                chk("type32", 64'(bus32.io_out_imm_type), 64'(q32[0].typ));
`ifdef YSYX_25030077_IMM_ALIGN_CHECK_EN
                chk("misalign32", 64'(bus32.io_out_misalign), 64'(q32[0].mis));
`endif
            end
            if (io_flush) begin
                q32.delete();
            end else begin
                if (bus32.io_out_valid && bus32.io_out_ready && q32.size() > 0)
                    void'(q32.pop_front());
                if (bus32.io_in_valid && bus32.io_in_ready)
                    q32.push_back(model(bus32.io_in_instruction, bus32.io_in_imm_type,
                                        64'(bus32.io_in_pc), 32));
            end
        end
    end

    // Scoreboard for the XLEN=64 instance, evaluated mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            q64.delete();
            chk("rst_valid64", 64'(bus64.io_out_valid), 64'd0);
            chk("rst_ready64", 64'(bus64.io_in_ready), 64'd1);
            chk("rst_imm64", bus64.io_out_imm, 64'd0);
            chk("rst_tgt64", bus64.io_out_target, 64'd0);
        end else begin
            chk("in_ready64", 64'(bus64.io_in_ready), 64'(q64.size() < 2));
            chk("out_valid64", 64'(bus64.io_out_valid), 64'(q64.size() > 0));
            if (bus64.io_out_valid && q64.size() > 0) begin
                chk("imm64", bus64.io_out_imm, q64[0].imm);
                chk("target64", bus64.io_out_target, q64[0].tgt);
                chk("type64", 64'(bus64.io_out_imm_type), 64'(q64[0].typ));
`ifdef YSYX_25030077_IMM_ALIGN_CHECK_EN
                chk("misalign64", 64'(bus64.io_out_misalign), 64'(q64[0].mis));
`endif
            end
            if (io_flush) begin
                q64.delete();
            end else begin
                if (bus64.io_out_valid && bus64.io_out_ready && q64.size() > 0)
                    void'(q64.pop_front());
                if (bus64.io_in_valid && bus64.io_in_ready)
                    q64.push_back(model(bus64.io_in_instruction, bus64.io_in_imm_type,
                                        bus64.io_in_pc, 64));
            end
        end
    end

    // Alternate io_out_ready every cycle while enabled.
    always @(posedge clock) begin
        if (rdy_toggle) begin
            #1;
            bus32.io_out_ready = ~bus32.io_out_ready;
            bus64.io_out_ready = ~bus64.io_out_ready;
        end
    end

    // Offer one entry (called just after a rising edge); returns just after the
    // edge that accepted it, leaving io_in_valid high.
    task automatic applyStimulus(input int sel, input logic [31:0] insn,
                                 input logic [3:0] typ, input logic [63:0] pc);
        int   waited;
        logic rdy;
        waited = 0;
        if (sel == 32) begin
            bus32.io_in_valid       = 1'b1;
            bus32.io_in_instruction = insn;
            bus32.io_in_imm_type    = typ;
            bus32.io_in_pc          = pc[31:0];
        end else begin
            bus64.io_in_valid       = 1'b1;
            bus64.io_in_instruction = insn;
            bus64.io_in_imm_type    = typ;
            bus64.io_in_pc          = pc;
        end
        do begin
            @(negedge clock);
            waited++;
            rdy = (sel == 32) ? bus32.io_in_ready : bus64.io_in_ready;
        end while (!rdy && waited < 50);
        if (!rdy) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=not_ready required=ready within 50 cycles");
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        bus32.io_in_valid = 1'b0;
        bus64.io_in_valid = 1'b0;
    endtask

    // Check the entry sitting in the output register against literal values.
    task automatic checkOutput(input int sel, input string name,
                               input logic [63:0] exp_imm, input logic [63:0] exp_tgt);
        @(negedge clock);
        if (sel == 32) begin
            chk({name, "_valid"}, 64'(bus32.io_out_valid), 64'd1);
            chk({name, "_imm"}, 64'(bus32.io_out_imm), exp_imm);
            chk({name, "_target"}, 64'(bus32.io_out_target), exp_tgt);
        end else begin
            chk({name, "_valid"}, 64'(bus64.io_out_valid), 64'd1);
            chk({name, "_imm"}, bus64.io_out_imm, exp_imm);
            chk({name, "_target"}, bus64.io_out_target, exp_tgt);
        end
        @(posedge clock);
        #1;
    endtask

    logic [31:0] words[4] = '{32'hFFF00093, 32'h8A5FF0E3, 32'h7FF0A5B7, 32'hDEADBEEF};
    logic [63:0] pcs[4]   = '{64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h8000_0002, 64'h1234};

    // Watchdog so the run always ends.
    initial begin
        #400000;
        failures++;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        io_flush   = 1'b0;
        rdy_toggle = 1'b0;
        bus32.io_in_valid = 1'b0; bus32.io_in_instruction = '0;
        bus32.io_in_imm_type = '0; bus32.io_in_pc = '0; bus32.io_out_ready = 1'b1;
        bus64.io_in_valid = 1'b0; bus64.io_in_instruction = '0;
        bus64.io_in_imm_type = '0; bus64.io_in_pc = '0; bus64.io_out_ready = 1'b1;

        // Pin the reference model to hand-computed values.
        e = model(32'hFE000EE3, 4'd7, 64'h8000_0010, 32);
        chk("model_b_imm", e.imm, 64'hFFFF_FFFC);
        e = model(32'h001000EF, 4'd8, 64'h8000_0000, 32);
        chk("model_j_imm", e.imm, 64'h0000_0800);
        e = model(32'h800002B7, 4'd2, 64'h0, 64);
        chk("model_u64_imm", e.imm, 64'hFFFF_FFFF_8000_0000);
        e = model(32'h03F01093, 4'd5, 64'h0, 32);
        chk("model_shamt32_imm", e.imm, 64'h1F);

        // Reset held for three edges, then released.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_hold_valid", 64'(bus32.io_out_valid), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("reset_rel_valid", 64'(bus32.io_out_valid), 64'd0);
        chk("reset_rel_ready", 64'(bus32.io_in_ready), 64'd1);
        chk("reset_rel_imm", 64'(bus32.io_out_imm), 64'd0);
        @(posedge clock);
        #1;

        // Single entries with literal expectations.
        applyStimulus(32, 32'hFFF00093, 4'd1, 64'h8000_0000); clearInputs();
        checkOutput(32, "i_type", 64'hFFFF_FFFF, 64'h7FFF_FFFF);
        applyStimulus(32, 32'hFE000EE3, 4'd7, 64'h8000_0010); clearInputs();
        checkOutput(32, "b_type", 64'hFFFF_FFFC, 64'h8000_000C);
        applyStimulus(32, 32'h001000EF, 4'd8, 64'h8000_0000); clearInputs();
        checkOutput(32, "j_type", 64'h0000_0800, 64'h8000_0800);
        applyStimulus(32, 32'h03F01093, 4'd5, 64'h1000); clearInputs();
        checkOutput(32, "shamt32", 64'h1F, 64'h101F);
        applyStimulus(64, 32'h800002B7, 4'd2, 64'h0); clearInputs();
        checkOutput(64, "u64", 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(64, 32'h03F01093, 4'd5, 64'h1000); clearInputs();
        checkOutput(64, "shamt64", 64'h3F, 64'h103F);
        applyStimulus(64, 32'h00000013, 4'd3, 64'hFFFF_FFFF_FFFF_FFFE); clearInputs();
        checkOutput(64, "pc4_wrap64", 64'h4, 64'h2);

        // Every selector 0..15 back-to-back, free-running then alternating ready.
        for (int pass = 0; pass < 2; pass++) begin
            rdy_toggle = (pass == 1);
            for (int t = 0; t < 16; t++) begin
                for (int w = 0; w < 4; w++) begin
                    applyStimulus(32, words[w], 4'(t), pcs[w]);
                    applyStimulus(64, words[w], 4'(t), pcs[w]);
                end
            end
            clearInputs();
            rdy_toggle = 1'b0;
            @(posedge clock);
            #1;
            bus32.io_out_ready = 1'b1;
            bus64.io_out_ready = 1'b1;
            repeat (4) @(posedge clock);
            #1;
        end

        // Back-pressure: A and B fill M and K, C must wait, then all drain in order.
        bus32.io_out_ready = 1'b0;
        applyStimulus(32, 32'h00100093, 4'd1, 64'h0);
        applyStimulus(32, 32'h00200093, 4'd1, 64'h0);
        bus32.io_in_instruction = 32'h00300093;
        @(negedge clock);
        chk("bp_ready_while_c", 64'(bus32.io_in_ready), 64'd0);
        chk("bp_head_a", 64'(bus32.io_out_imm), 64'd1);
        @(posedge clock);
        #1 bus32.io_out_ready = 1'b1;
        @(negedge clock);
        chk("bp_out_a_valid", 64'(bus32.io_out_valid), 64'd1);
        chk("bp_out_a", 64'(bus32.io_out_imm), 64'd1);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("bp_out_b_valid", 64'(bus32.io_out_valid), 64'd1);
        chk("bp_out_b", 64'(bus32.io_out_imm), 64'd2);
        @(posedge clock);
        #1 clearInputs();
        @(negedge clock);
        chk("bp_out_c_valid", 64'(bus32.io_out_valid), 64'd1);
        chk("bp_out_c", 64'(bus32.io_out_imm), 64'd3);
        @(posedge clock);
        #1;

        // Flush with M and K full and a third entry offered.
        bus32.io_out_ready = 1'b0;
        applyStimulus(32, 32'h00400093, 4'd1, 64'h0);
        applyStimulus(32, 32'h00500093, 4'd1, 64'h0);
        bus32.io_in_instruction = 32'h00600093;
        io_flush = 1'b1;
        @(negedge clock);
        chk("flush_pre_ready", 64'(bus32.io_in_ready), 64'd0);
        @(posedge clock);
        #1;
        io_flush = 1'b0;
        clearInputs();
        bus32.io_out_ready = 1'b1;
        @(negedge clock);
        chk("flush_post_valid", 64'(bus32.io_out_valid), 64'd0);
        chk("flush_post_ready", 64'(bus32.io_in_ready), 64'd1);
        repeat (4) @(posedge clock);
        #1;

        // Asynchronous reset in the middle of back-pressure.
        bus32.io_out_ready = 1'b0;
        applyStimulus(32, 32'h00700093, 4'd1, 64'h0);
        applyStimulus(32, 32'h00800093, 4'd1, 64'h0);
        clearInputs();
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus32.io_out_valid), 64'd0);
        chk("async_rst_ready", 64'(bus32.io_in_ready), 64'd1);
        chk("async_rst_imm", 64'(bus32.io_out_imm), 64'd0);
        chk("async_rst_target", 64'(bus32.io_out_target), 64'd0);
        chk("async_rst_type", 64'(bus32.io_out_imm_type), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus32.io_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        applyStimulus(32, 32'h00900093, 4'd1, 64'h10); clearInputs();
        checkOutput(32, "after_reset", 64'h9, 64'h19);
        repeat (2) @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
